// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write register file with write-to-read
// bypass, a power-up clear sequencer and a per-register pending scoreboard.
// Decode reads and issues into it; writeback writes into it.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            init_busy,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            pend1,
  output logic            pend2
);

  localparam int DEPTH = 2 ** AW;
  localparam bit ZR    = (ZERO_REG != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            r_state;
  state_e            w_state_nxt;
  logic [AW-1:0]     r_clr_cnt;
  logic [AW-1:0]     w_clr_cnt_nxt;
  logic [XLEN-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_pending_nxt;

  // Array write port, shared between the clear sequencer and writeback.
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_waddr;
  logic [XLEN-1:0]   w_mem_wdata;

  // Qualified writeback: a write to the hard-wired zero register is dropped.
  logic              w_ready;
  logic              w_wr_ok;
  logic              w_issue_ok;
  logic [XLEN-1:0]   w_mem_rd1;
  logic [XLEN-1:0]   w_mem_rd2;

  assign w_ready    = (r_state == ST_READY);
  assign w_wr_ok    = we && !(ZR && (waddr == '0));
  assign w_issue_ok = issue_valid && !(ZR && (issue_rd == '0));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State and clear-counter registers; reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement or block ordering.
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Next-state logic: walk every entry once, then hand over to normal operation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    init_busy     = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        init_busy     = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + AW'(1);
        if (r_clr_cnt == {AW{1'b1}}) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------

  // Write-port mux: the sequencer owns the port while clearing, writeback after.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = waddr;
    w_mem_wdata = wdata;
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_clr_cnt;
        w_mem_wdata = '0;
      end else begin
        w_mem_we    = w_wr_ok;
      end
    end
  end

  // Array write; contents are zeroed by the sequencer rather than by reset.
  always_ff @(posedge clk) begin
    // NOTE: the array deliberately has no reset term so it can map onto RAM
    // macros; the clear sequencer provides the defined initial contents.
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign w_mem_rd1 = r_mem[ra1];
  assign w_mem_rd2 = r_mem[ra2];

  // One read port: zero register, then same-cycle bypass, then the array.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   ra,
    input logic [XLEN-1:0] mem_data,
    input logic            ready,
    input logic            wr_ok,
    input logic [AW-1:0]   wa,
    input logic [XLEN-1:0] wd
  );
    logic [XLEN-1:0] v;
    v = '0;
    if (!ready) begin
      v = '0;
    end else if (ZR && (ra == '0)) begin
      v = '0;
    end else if (wr_ok && (wa == ra)) begin
      v = wd;
    end else begin
      v = mem_data;
    end
    return v;
  endfunction

  // Combinational read data for both ports.
  always_comb begin
    rd1 = read_port(ra1, w_mem_rd1, w_ready, w_wr_ok, waddr, wdata);
    rd2 = read_port(ra2, w_mem_rd2, w_ready, w_wr_ok, waddr, wdata);
  end

  // ---------------------------------------------------------------------------
  // Pending scoreboard
  // ---------------------------------------------------------------------------

  // Scoreboard update: retire on write, then mark new producer (set wins).
  always_comb begin
    w_pending_nxt = r_pending;
    if (we) begin
      w_pending_nxt[waddr] = 1'b0;
    end
    if (w_issue_ok) begin
      w_pending_nxt[issue_rd] = 1'b1;
    end
    if (ZR) begin
      w_pending_nxt[0] = 1'b0;
    end
  end

  // Scoreboard register; frozen while clearing so stray issues are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else if (w_ready) begin
      r_pending <= w_pending_nxt;
    end
  end

  // Hazard outputs; a value being written this cycle is available via bypass.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    if (w_ready) begin
      pend1 = r_pending[ra1] && !(we && (waddr == ra1));
      pend2 = r_pending[ra2] && !(we && (waddr == ra2));
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32 instance with a zero register
// and a small 8x16 instance without one. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default instance (XLEN=32, AW=5, ZERO_REG=1)
  logic        reset;
  logic        init_busy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        pend1, pend2;

  regfile_sb u_dut (
    .clk         (clk),
    .reset       (reset),
    .init_busy   (init_busy),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .pend1       (pend1),
    .pend2       (pend2)
  );

  // Small instance (XLEN=16, AW=3, ZERO_REG=0)
  logic        s_reset;
  logic        s_init_busy;
  logic        s_we;
  logic [2:0]  s_waddr;
  logic [15:0] s_wdata;
  logic [2:0]  s_ra1, s_ra2;
  logic [15:0] s_rd1, s_rd2;
  logic        s_issue_valid;
  logic [2:0]  s_issue_rd;
  logic        s_pend1, s_pend2;

  regfile_sb #(.XLEN(16), .AW(3), .ZERO_REG(0)) u_dut_s (
    .clk         (clk),
    .reset       (s_reset),
    .init_busy   (s_init_busy),
    .we          (s_we),
    .waddr       (s_waddr),
    .wdata       (s_wdata),
    .ra1         (s_ra1),
    .ra2         (s_ra2),
    .rd1         (s_rd1),
    .rd2         (s_rd2),
    .issue_valid (s_issue_valid),
    .issue_rd    (s_issue_rd),
    .pend1       (s_pend1),
    .pend2       (s_pend2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From the drive point, move to the falling edge (sample point).
  task automatic settle();
    #4;
  endtask

  int busy_cycles;

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; ra1 = '0; ra2 = '0;
    issue_valid = 1'b0; issue_rd = '0;
    s_reset = 1'b1; s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_ra1 = '0; s_ra2 = '0;
    s_issue_valid = 1'b0; s_issue_rd = '0;

    // ---- Reset held 3 cycles ----
    repeat (3) step();
    settle();
    check("reset_init_busy", 32'(init_busy), 32'd1);
    check("reset_rd1", rd1, 32'd0);
    check("reset_rd2", rd2, 32'd0);
    check("reset_pend1", 32'(pend1), 32'd0);
    check("reset_pend2", 32'(pend2), 32'd0);
    step();
    reset = 1'b0;

    // ---- Clear length: init_busy high for exactly 32 cycles ----
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      settle();
      if (!init_busy) break;
      busy_cycles++;
      step();
    end
    check("clear_cycles", 32'(busy_cycles), 32'd32);
    step();

    // ---- Every address reads 0, nothing pending ----
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a);
      ra2 = 5'(31 - a);
      settle();
      check("post_clear_rd1", rd1, 32'd0);
      check("post_clear_rd2", rd2, 32'd0);
      check("post_clear_pend1", 32'(pend1), 32'd0);
      check("post_clear_pend2", 32'(pend2), 32'd0);
      step();
    end

    // ---- Bypass and array write on x5 ----
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; ra1 = 5'd5;
    settle();
    check("bypass_x5", rd1, 32'hDEADBEEF);
    step();
    we = 1'b0; wdata = 32'h0;
    settle();
    check("array_x5", rd1, 32'hDEADBEEF);
    step();

    // ---- Write to x0 dropped ----
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; ra1 = 5'd0;
    settle();
    check("x0_no_bypass", rd1, 32'd0);
    step();
    we = 1'b0;
    settle();
    check("x0_still_zero", rd1, 32'd0);
    step();

    // ---- Top entry, both ports distinct ----
    we = 1'b1; waddr = 5'd31; wdata = 32'h31313131;
    step();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd31;
    settle();
    check("dual_rd1_x5", rd1, 32'hDEADBEEF);
    check("dual_rd2_x31", rd2, 32'h31313131);
    step();

    // ---- Issue x7, then writeback ----
    issue_valid = 1'b1; issue_rd = 5'd7; ra2 = 5'd7;
    settle();
    check("issue_x7_same_cycle", 32'(pend2), 32'd0);
    step();
    issue_valid = 1'b0;
    settle();
    check("pend_x7_t", 32'(pend2), 32'd1);
    step();
    settle();
    check("pend_x7_t1", 32'(pend2), 32'd1);
    step();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A50007;
    settle();
    check("wb_x7_pend", 32'(pend2), 32'd0);
    check("wb_x7_bypass", rd2, 32'hA5A50007);
    step();
    we = 1'b0;
    settle();
    check("after_wb_x7_pend", 32'(pend2), 32'd0);
    check("after_wb_x7_rd", rd2, 32'hA5A50007);
    step();

    // ---- Same-edge issue and write on x9: set wins ----
    issue_valid = 1'b1; issue_rd = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h00000099;
    ra1 = 5'd9;
    settle();
    check("x9_same_edge_pend", 32'(pend1), 32'd0);
    step();
    issue_valid = 1'b0; we = 1'b0;
    settle();
    check("x9_still_pending", 32'(pend1), 32'd1);
    check("x9_data_landed", rd1, 32'h00000099);
    step();

    // ---- Issue x0 never pends ----
    issue_valid = 1'b1; issue_rd = 5'd0; ra1 = 5'd0;
    step();
    issue_valid = 1'b0;
    settle();
    check("x0_never_pending", 32'(pend1), 32'd0);
    step();

    // ---- Write to another register leaves x12 pending ----
    issue_valid = 1'b1; issue_rd = 5'd12;
    step();
    issue_valid = 1'b0; we = 1'b1; waddr = 5'd13; wdata = 32'h13; ra1 = 5'd12;
    settle();
    check("x12_pending_other_wr", 32'(pend1), 32'd1);
    step();
    we = 1'b0;

    // ---- Reset in READY, pulse again at clear cycle 10 ----
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    check("ready_reset_busy", 32'(init_busy), 32'd1);
    step();
    for (int i = 1; i < 10; i++) step();
    reset = 1'b1;
    settle();
    check("clear10_busy", 32'(init_busy), 32'd1);
    step();
    reset = 1'b0;

    // Hammer writes and issues on x3 through the whole restarted clear.
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
      issue_valid = 1'b1; issue_rd = 5'd3; ra1 = 5'd3; ra2 = 5'd3;
      settle();
      check("restart_busy", 32'(init_busy), 32'd1);
      check("clear_rd1_zero", rd1, 32'd0);
      check("clear_pend1_zero", 32'(pend1), 32'd0);
      step();
    end
    we = 1'b0; issue_valid = 1'b0; ra2 = 5'd12;
    settle();
    check("restart_done", 32'(init_busy), 32'd0);
    check("x3_write_ignored", rd1, 32'd0);
    check("x3_issue_ignored", 32'(pend1), 32'd0);
    check("x12_pend_reset", 32'(pend2), 32'd0);
    step();
    ra1 = 5'd5;
    settle();
    check("x5_recleared", rd1, 32'd0);
    step();

    // ---- Small instance: AW=3, XLEN=16, ZERO_REG=0 ----
    s_reset = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      settle();
      if (!s_init_busy) break;
      busy_cycles++;
      step();
    end
    check("s_clear_cycles", 32'(busy_cycles), 32'd8);
    step();
    s_we = 1'b1; s_waddr = 3'd0; s_wdata = 16'hBEEF; s_ra1 = 3'd0;
    settle();
    check("s_x0_bypass", 32'(s_rd1), 32'h0000BEEF);
    step();
    s_we = 1'b0; s_wdata = 16'h0;
    settle();
    check("s_x0_array", 32'(s_rd1), 32'h0000BEEF);
    step();
    s_we = 1'b1; s_waddr = 3'd7; s_wdata = 16'h7777;
    step();
    s_we = 1'b0; s_ra1 = 3'd7;
    settle();
    check("s_x7_array", 32'(s_rd1), 32'h00007777);
    step();
    s_issue_valid = 1'b1; s_issue_rd = 3'd0; s_ra2 = 3'd0;
    settle();
    check("s_x0_issue_cycle", 32'(s_pend2), 32'd0);
    step();
    s_issue_valid = 1'b0;
    settle();
    check("s_x0_pending", 32'(s_pend2), 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised 2-read/1-write register file for the five-stage pipeline, successor to the fixed 32x32 file. Adds clocked writes, a write-to-read bypass, a hardware clear sequencer (so the array maps to RAM-style storage with no per-entry reset) and a per-register pending scoreboard for hazard detection in decode. It sits between decode (reads, issue) and writeback (write).

## Interface
- XLEN, 32, data width in bits.
- AW, 5, address width; the file holds 2**AW entries.
- ZERO_REG, 1, when 1, entry 0 reads as 0, ignores writes and is never pending.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- init_busy  out  1  high while the clear sequencer runs.
- we  in  1  writeback write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- ra1, ra2  in  AW  read addresses.
- rd1, rd2  out  XLEN  read data, combinational.
- issue_valid  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  AW  destination of the issued instruction.
- pend1, pend2  out  1  ra1/ra2 has an outstanding producer whose value is not yet available; combinational.

## Operation
- FSM states: CLEAR and READY.
  - Reset forces CLEAR, clear counter = 0, all pending bits = 0.
  - In CLEAR, each cycle writes 0 to entry[counter] and increments the counter.
  - When the counter reaches 2**AW-1, that entry is written and the FSM goes to READY.
- In CLEAR: we and issue_valid are ignored; rd1/rd2 = 0; pend1/pend2 = 0; init_busy = 1.
- Write (READY): on the edge with we=1, entry[waddr] <= wdata. If ZERO_REG=1 and waddr=0, the write is dropped.
- Read (READY), port n:
  - if ZERO_REG=1 and ran=0: rdn = 0;
  - else if we=1 and waddr=ran (write not dropped): rdn = wdata (bypass);
  - else rdn = entry[ran].
- Scoreboard, one bit per entry, updated in READY only:
  - we=1 clears pending[waddr].
  - issue_valid=1 sets pending[issue_rd].
  - If both hit the same address on the same edge, set wins: a new producer supersedes the retiring one.
  - With ZERO_REG=1, bit 0 is never set.
- Pending output: pendn = pending[ran] & ~(we & waddr==ran). A value being written this cycle counts as available through the bypass.
- Writes to a non-pending register are legal; the data is written and the scoreboard is unchanged.

## Timing
- Reset values: init_busy=1, rd1=rd2=0, pend1=pend2=0, all pending bits 0, counter 0.
- Clear takes exactly 2**AW cycles after reset deasserts. init_busy falls on the edge that writes the last entry, so the first READY cycle is cycle 2**AW after release. The default configuration takes 32 cycles.
- Reset asserted mid-clear or in READY restarts the clear from entry 0 on the next edge. Reset dominates every other input.
- Write-to-read latency is 0 cycles through the bypass. Array contents update at the write edge.
- Issue-to-pend latency is 1 cycle: the pend output reflects an issue from the previous edge.
- Read paths are purely combinational from ra/we/waddr/wdata. No registered outputs other than FSM and scoreboard state.

## Test plan
- Reset held 3 cycles then released, default parameters: init_busy=1 for exactly 32 cycles; afterwards every address reads 0 and pend1/pend2=0.
- Write 0xDEADBEEF to x5 with ra1=5 in the same cycle: rd1=0xDEADBEEF that cycle (bypass), and still 0xDEADBEEF next cycle with we=0. Write 0x1234 to x0: rd1 for ra1=0 stays 0.
- Issue x7 at edge t with ra2=7: pend2=1 from t until the writeback cycle. In the cycle with we=1, waddr=7, pend2=0 and rd2=wdata. After that edge, pend2 stays 0.
- Same edge carries issue_rd=9 and we with waddr=9: the write lands, pending[9] stays 1, pend1 for ra1=9 is 1 the following cycle.
- Reset pulsed at clear cycle 10: init_busy stays high and the clear restarts. A write attempted during clear (x3=0xFF) is ignored, so x3 reads 0 once READY.
- AW=3, XLEN=16, ZERO_REG=0: clear takes 8 cycles; x0 accepts 0xBEEF and reads it back; x0 can be marked pending.
